pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a five-stage in-order pipeline: stall/flush/bubble control,
// EX operand and store-data forwarding, a halt-drain FSM and saturating event counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW    = 4,
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_regwrt,
    input  logic              id_load,
    input  logic              id_store,
    input  logic              id_halt,
    input  logic              id_br_taken,
    input  logic              imem_busy,
    input  logic              dmem_busy,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_we,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_fwd,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              regwrt;
        logic              load;
        logic              store;
    } shadow_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    shadow_t       id_sh, ex_q, mem_q, wb_q;
    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    logic          freeze, load_use, branch, halt_acc, stall_ev;

    // A stage only produces a value when it really writes a nonzero register.
    function automatic logic reg_match(input shadow_t s, input logic [REG_AW-1:0] r);
        return s.valid && s.regwrt && (s.rd != '0) && (s.rd == r);
    endfunction

    assign id_sh = '{valid: id_valid, rs: id_rs, rt: id_rt, rd: id_rd,
                     regwrt: id_regwrt, load: id_load, store: id_store};

    assign freeze   = dmem_busy;
    assign load_use = ex_q.load &&
                      ((id_rs_used && reg_match(ex_q, id_rs)) ||
                       (id_rt_used && !id_store && reg_match(ex_q, id_rt)));
    assign branch   = id_valid && id_br_taken;
    assign halt_acc = (state == RUN) && id_valid && id_halt && !freeze && !load_use;
    assign stall_ev = (state == RUN) && (freeze || load_use);
    assign halted   = (state == HALT);

    always_comb begin
        fwd_a = 2'b00;
        if (reg_match(mem_q, ex_q.rs) && !mem_q.load) fwd_a = 2'b10;
        else if (reg_match(wb_q, ex_q.rs))            fwd_a = 2'b01;
        fwd_b = 2'b00;
        if (reg_match(mem_q, ex_q.rt) && !mem_q.load) fwd_b = 2'b10;
        else if (reg_match(wb_q, ex_q.rt))            fwd_b = 2'b01;
    end

    assign mem_fwd = mem_q.valid && mem_q.store && reg_match(wb_q, mem_q.rt);

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            RUN: begin
                if (halt_acc) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = DW'(DRAIN_CYC);
                end
            end
            DRAIN: begin
                if (pipe_we && (drain_cnt != '0)) drain_cnt_nxt = drain_cnt - DW'(1);
                if (drain_cnt_nxt == '0)          state_nxt     = HALT;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: every output takes its free-running value first, so no branch can infer a latch.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_we     = 1'b1;
        if (freeze) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            pipe_we = 1'b0;
        end else if (state != RUN || load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else if (branch) begin
            ifid_flush = 1'b1;
        end else if (imem_busy) begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    // NOTE: non-blocking assignments let each stage capture its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            drain_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt_nxt;
            if (pipe_we) begin
                ex_q  <= idex_bubble ? '0 : id_sh;
                mem_q <= ex_q;
                wb_q  <= mem_q;
            end
            if (stall_ev && (stall_cnt != '1))  stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // Shadow fields kept for completeness but not consumed by any hazard rule.
    logic unused_shadow_bits;
    assign unused_shadow_bits = ^{ex_q.store, mem_q.rs, wb_q.rs, wb_q.rt, wb_q.load, wb_q.store};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario bench for pipe_hazard_ctrl: per-cycle control expectations are queued when
// stimulus is driven and compared once the combinational outputs settle.
module tb_pipe_hazard_ctrl;

    localparam int AW = 4;
    localparam int CW = 16;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs, rt, rd;
        logic          rs_used, rt_used, regwrt, load, store, halt, br, imem, dmem;
    } stim_t;

    typedef struct packed {
        logic       pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we;
        logic [1:0] fwd_a, fwd_b;
        logic       mem_fwd, halted;
    } ctl_t;

    localparam ctl_t C_RUN = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam ctl_t C_LU  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam ctl_t C_DR  = C_LU;
    localparam ctl_t C_FRZ = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam ctl_t C_BR  = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam ctl_t C_IM  = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid, id_rs_used, id_rt_used, id_regwrt, id_load, id_store, id_halt;
    logic id_br_taken, imem_busy, dmem_busy;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we, mem_fwd, halted;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic pc_we_s, ifid_we_s, ifid_flush_s, idex_bubble_s, pipe_we_s, mem_fwd_s, halted_s;
    logic [1:0] fwd_a_s, fwd_b_s, stall_cnt_s, flush_cnt_s;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_regwrt(id_regwrt),
        .id_load(id_load), .id_store(id_store), .id_halt(id_halt), .id_br_taken(id_br_taken),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_we(pipe_we),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fwd(mem_fwd), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_regwrt(id_regwrt),
        .id_load(id_load), .id_store(id_store), .id_halt(id_halt), .id_br_taken(id_br_taken),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy), .pc_we(pc_we_s), .ifid_we(ifid_we_s),
        .ifid_flush(ifid_flush_s), .idex_bubble(idex_bubble_s), .pipe_we(pipe_we_s),
        .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .mem_fwd(mem_fwd_s), .halted(halted_s),
        .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    ctl_t obs, obs_sat, want;
    assign obs     = {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we, fwd_a, fwd_b, mem_fwd, halted};
    assign obs_sat = {pc_we_s, ifid_we_s, ifid_flush_s, idex_bubble_s, pipe_we_s,
                      fwd_a_s, fwd_b_s, mem_fwd_s, halted_s};

    int checks = 0;
    int errors = 0;
    ctl_t exp_q[$];
    stim_t st_tab[16];
    ctl_t exp_tab[16];
    logic sb_tab[16];
    int n;
    logic [CW-1:0] stall_m, flush_m;
    logic [1:0] sat_m;

    function automatic ctl_t cx(ctl_t b, logic [1:0] fa, logic [1:0] fb, logic mf, logic h);
        b.fwd_a = fa; b.fwd_b = fb; b.mem_fwd = mf; b.halted = h;
        return b;
    endfunction

    function automatic stim_t s_nop();
        return '0;
    endfunction

    function automatic stim_t s_alu(logic [AW-1:0] rd, logic [AW-1:0] rs, logic [AW-1:0] rt,
                                    logic ru, logic tu);
        stim_t s = '0;
        s.valid = 1'b1; s.regwrt = 1'b1; s.rd = rd; s.rs = rs; s.rt = rt;
        s.rs_used = ru; s.rt_used = tu;
        return s;
    endfunction

    function automatic stim_t s_load(logic [AW-1:0] rd);
        stim_t s = '0;
        s.valid = 1'b1; s.regwrt = 1'b1; s.load = 1'b1; s.rd = rd;
        return s;
    endfunction

    function automatic stim_t s_store(logic [AW-1:0] rt);
        stim_t s = '0;
        s.valid = 1'b1; s.store = 1'b1; s.rt = rt; s.rt_used = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_br();
        stim_t s = '0;
        s.valid = 1'b1; s.br = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_halt();
        stim_t s = '0;
        s.valid = 1'b1; s.halt = 1'b1;
        return s;
    endfunction

    function automatic stim_t busy(stim_t s, logic im, logic dm);
        s.imem = im; s.dmem = dm;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        id_valid = s.valid; id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
        id_rs_used = s.rs_used; id_rt_used = s.rt_used; id_regwrt = s.regwrt;
        id_load = s.load; id_store = s.store; id_halt = s.halt; id_br_taken = s.br;
        imem_busy = s.imem; dmem_busy = s.dmem;
    endtask

    task automatic add(input stim_t s, input ctl_t e, input logic stl);
        st_tab[n] = s; exp_tab[n] = e; sb_tab[n] = stl; n++;
    endtask

    task automatic do_reset();
        apply(s_nop());
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall_m = '0;
        flush_m = '0;
    endtask

    task automatic test_reset();
        string nm = "reset";
        apply(s_nop());
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(C_RUN);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin errors++; $display("FAIL %s controls got %b want %b", nm, obs, want); end
        checks++;
        if (obs_sat !== C_RUN) begin errors++; $display("FAIL %s sat controls got %b want %b", nm, obs_sat, C_RUN); end
        checks++;
        if (stall_cnt !== '0) begin errors++; $display("FAIL %s stall_cnt got %0d want 0", nm, stall_cnt); end
        checks++;
        if (flush_cnt !== '0) begin errors++; $display("FAIL %s flush_cnt got %0d want 0", nm, flush_cnt); end
        checks++;
        if (flush_cnt_s !== 2'd0) begin errors++; $display("FAIL %s sat flush_cnt got %0d want 0", nm, flush_cnt_s); end
    endtask

    task automatic test_load_use();
        string nm = "load_use";
        do_reset();
        n = 0;
        add(s_load(3), C_RUN, 0);
        add(s_alu(4, 3, 0, 1, 0), C_LU, 1);
        add(s_alu(4, 3, 0, 1, 0), C_RUN, 0);
        add(s_load(3), cx(C_RUN, 2'b01, 2'b00, 0, 0), 0);
        add(s_alu(5, 0, 3, 0, 1), C_LU, 1);
        add(s_alu(5, 0, 3, 0, 1), C_RUN, 0);
        add(s_load(0), cx(C_RUN, 2'b00, 2'b01, 0, 0), 0);
        add(s_alu(6, 0, 0, 1, 0), C_RUN, 0);
        add(s_nop(), C_RUN, 0);
        for (int i = 0; i < n; i++) begin
            apply(st_tab[i]);
            exp_q.push_back(exp_tab[i]);
            if (sb_tab[i]) stall_m = stall_m + 16'd1;
            if (exp_tab[i].ifid_flush) flush_m = flush_m + 16'd1;
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin errors++; $display("FAIL %s row %0d controls got %b want %b", nm, i, obs, want); end
            @(posedge clk);
            #1;
        end
        checks++;
        if (stall_cnt !== stall_m) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, stall_m); end
        checks++;
        if (flush_cnt !== flush_m) begin errors++; $display("FAIL %s flush_cnt got %0d want %0d", nm, flush_cnt, flush_m); end
    endtask

    task automatic test_fwd_priority();
        string nm = "fwd_priority";
        do_reset();
        n = 0;
        add(s_alu(5, 0, 0, 0, 0), C_RUN, 0);
        add(s_alu(5, 0, 0, 0, 0), C_RUN, 0);
        add(s_alu(6, 5, 5, 1, 1), C_RUN, 0);
        add(s_nop(), cx(C_RUN, 2'b10, 2'b10, 0, 0), 0);
        add(s_alu(0, 0, 0, 0, 0), C_RUN, 0);
        add(s_alu(0, 0, 0, 0, 0), C_RUN, 0);
        add(s_alu(1, 0, 0, 1, 1), C_RUN, 0);
        add(s_nop(), C_RUN, 0);
        add(s_alu(7, 0, 0, 0, 0), C_RUN, 0);
        add(s_load(7), C_RUN, 0);
        add(s_store(7), C_RUN, 0);
        add(s_nop(), cx(C_RUN, 2'b00, 2'b01, 0, 0), 0);
        add(s_nop(), cx(C_RUN, 2'b00, 2'b00, 1, 0), 0);
        add(s_nop(), C_RUN, 0);
        for (int i = 0; i < n; i++) begin
            apply(st_tab[i]);
            exp_q.push_back(exp_tab[i]);
            if (sb_tab[i]) stall_m = stall_m + 16'd1;
            if (exp_tab[i].ifid_flush) flush_m = flush_m + 16'd1;
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin errors++; $display("FAIL %s row %0d controls got %b want %b", nm, i, obs, want); end
            @(posedge clk);
            #1;
        end
        checks++;
        if (stall_cnt !== stall_m) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, stall_m); end
    endtask

    task automatic test_store_fwd();
        string nm = "store_fwd";
        do_reset();
        n = 0;
        add(s_load(2), C_RUN, 0);
        add(s_store(2), C_RUN, 0);
        add(s_nop(), C_RUN, 0);
        add(s_nop(), cx(C_RUN, 2'b00, 2'b00, 1, 0), 0);
        add(s_nop(), C_RUN, 0);
        for (int i = 0; i < n; i++) begin
            apply(st_tab[i]);
            exp_q.push_back(exp_tab[i]);
            if (sb_tab[i]) stall_m = stall_m + 16'd1;
            if (exp_tab[i].ifid_flush) flush_m = flush_m + 16'd1;
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin errors++; $display("FAIL %s row %0d controls got %b want %b", nm, i, obs, want); end
            @(posedge clk);
            #1;
        end
        checks++;
        if (stall_cnt !== stall_m) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, stall_m); end
    endtask

    task automatic test_freeze_branch();
        string nm = "freeze_branch";
        do_reset();
        n = 0;
        add(s_alu(4, 0, 0, 0, 0), C_RUN, 0);
        add(s_alu(8, 4, 0, 1, 0), C_RUN, 0);
        for (int k = 0; k < 4; k++) add(busy(s_br(), 0, 1), cx(C_FRZ, 2'b10, 2'b00, 0, 0), 1);
        add(s_br(), cx(C_BR, 2'b10, 2'b00, 0, 0), 0);
        add(s_nop(), C_RUN, 0);
        for (int i = 0; i < n; i++) begin
            apply(st_tab[i]);
            exp_q.push_back(exp_tab[i]);
            if (sb_tab[i]) stall_m = stall_m + 16'd1;
            if (exp_tab[i].ifid_flush) flush_m = flush_m + 16'd1;
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin errors++; $display("FAIL %s row %0d controls got %b want %b", nm, i, obs, want); end
            @(posedge clk);
            #1;
        end
        checks++;
        if (stall_cnt !== stall_m) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, stall_m); end
        checks++;
        if (flush_cnt !== flush_m) begin errors++; $display("FAIL %s flush_cnt got %0d want %0d", nm, flush_cnt, flush_m); end
    endtask

    task automatic test_imem_priority();
        string nm = "imem_priority";
        stim_t t;
        do_reset();
        n = 0;
        add(busy(s_nop(), 1, 0), C_IM, 0);
        add(busy(s_load(9), 1, 0), C_IM, 0);
        t = busy(s_alu(1, 9, 0, 1, 0), 1, 0);
        t.br = 1'b1;
        add(t, C_LU, 1);
        add(busy(s_br(), 1, 0), C_BR, 0);
        t = s_br();
        t.valid = 1'b0;
        add(t, C_RUN, 0);
        for (int i = 0; i < n; i++) begin
            apply(st_tab[i]);
            exp_q.push_back(exp_tab[i]);
            if (sb_tab[i]) stall_m = stall_m + 16'd1;
            if (exp_tab[i].ifid_flush) flush_m = flush_m + 16'd1;
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin errors++; $display("FAIL %s row %0d controls got %b want %b", nm, i, obs, want); end
            @(posedge clk);
            #1;
        end
        checks++;
        if (stall_cnt !== stall_m) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, stall_m); end
        checks++;
        if (flush_cnt !== flush_m) begin errors++; $display("FAIL %s flush_cnt got %0d want %0d", nm, flush_cnt, flush_m); end
    endtask

    task automatic test_halt();
        string nm = "halt";
        do_reset();
        n = 0;
        add(busy(s_halt(), 0, 1), C_FRZ, 1);
        add(s_halt(), C_RUN, 0);
        add(s_nop(), C_DR, 0);
        add(busy(s_nop(), 0, 1), C_FRZ, 0);
        add(busy(s_nop(), 0, 1), C_FRZ, 0);
        add(s_nop(), C_DR, 0);
        add(s_nop(), C_DR, 0);
        add(s_nop(), cx(C_DR, 2'b00, 2'b00, 0, 1), 0);
        add(busy(s_br(), 1, 0), cx(C_DR, 2'b00, 2'b00, 0, 1), 0);
        add(busy(s_nop(), 0, 1), cx(C_FRZ, 2'b00, 2'b00, 0, 1), 0);
        for (int i = 0; i < n; i++) begin
            apply(st_tab[i]);
            exp_q.push_back(exp_tab[i]);
            if (sb_tab[i]) stall_m = stall_m + 16'd1;
            if (exp_tab[i].ifid_flush) flush_m = flush_m + 16'd1;
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin errors++; $display("FAIL %s row %0d controls got %b want %b", nm, i, obs, want); end
            @(posedge clk);
            #1;
        end
        checks++;
        if (stall_cnt !== stall_m) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, stall_m); end
        checks++;
        if (flush_cnt !== flush_m) begin errors++; $display("FAIL %s flush_cnt got %0d want %0d", nm, flush_cnt, flush_m); end
        do_reset();
        exp_q.push_back(C_RUN);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin errors++; $display("FAIL %s after_rst controls got %b want %b", nm, obs, want); end
    endtask

    task automatic test_reset_mid();
        string nm = "reset_mid";
        do_reset();
        n = 0;
        add(s_halt(), C_RUN, 0);
        add(busy(s_nop(), 0, 1), C_FRZ, 0);
        for (int i = 0; i < n; i++) begin
            apply(st_tab[i]);
            exp_q.push_back(exp_tab[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin errors++; $display("FAIL %s row %0d controls got %b want %b", nm, i, obs, want); end
            @(posedge clk);
            #1;
        end
        apply(busy(s_nop(), 0, 1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall_m = '0;
        flush_m = '0;
        n = 0;
        for (int k = 0; k < 4; k++) add(s_nop(), C_RUN, 0);
        for (int i = 0; i < n; i++) begin
            apply(st_tab[i]);
            exp_q.push_back(exp_tab[i]);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin errors++; $display("FAIL %s post row %0d controls got %b want %b", nm, i, obs, want); end
            @(posedge clk);
            #1;
        end
        checks++;
        if (stall_cnt !== stall_m) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, stall_m); end
    endtask

    task automatic test_saturation();
        string nm = "saturation";
        do_reset();
        n = 0;
        for (int k = 0; k < 5; k++) add(busy(s_nop(), 1, 0), C_IM, 0);
        for (int i = 0; i < n; i++) begin
            apply(st_tab[i]);
            exp_q.push_back(exp_tab[i]);
            if (exp_tab[i].ifid_flush) flush_m = flush_m + 16'd1;
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs_sat !== want) begin errors++; $display("FAIL %s row %0d sat controls got %b want %b", nm, i, obs_sat, want); end
            @(posedge clk);
            #1;
        end
        sat_m = (flush_m > 16'd3) ? 2'd3 : flush_m[1:0];
        checks++;
        if (flush_cnt !== flush_m) begin errors++; $display("FAIL %s flush_cnt got %0d want %0d", nm, flush_cnt, flush_m); end
        checks++;
        if (flush_cnt_s !== sat_m) begin errors++; $display("FAIL %s sat flush_cnt got %0d want %0d", nm, flush_cnt_s, sat_m); end
        checks++;
        if (stall_cnt_s !== 2'd0) begin errors++; $display("FAIL %s sat stall_cnt got %0d want 0", nm, stall_cnt_s); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        apply(s_nop());
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_store_fwd();
        test_freeze_branch();
        test_imem_priority();
        test_halt();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
